instruction_fetch_unit: RTL and testbench

INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

---
 rtl/instruction_fetch_unit_pkg.sv | 21 ++
 rtl/instruction_fetch_unit_queue.sv | 59 +++++
 rtl/instruction_fetch_unit.sv | 95 +++++++++
 tb/tb_instruction_fetch_unit.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/instruction_fetch_unit_pkg.sv
// Shared processor types for the fetch path: FSM state encoding, queue entry
// layout and the NOP word driven when no instruction is available.
package ProcessorStructs;

  localparam int unsigned PKG_IBUS = 32;
  localparam int unsigned PKG_ABUS = 32;

  typedef enum logic [1:0] {
    FETCH      = 2'd0,
    WAIT_SPACE = 2'd1,
    DRAIN      = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [PKG_ABUS-1:0] pc;
    logic [PKG_IBUS-1:0] instr;
  } fetch_entry_t;

  localparam logic [PKG_IBUS-1:0] NOP = '0;

endpackage

// File: rtl/instruction_fetch_unit_queue.sv
// Power-of-two FIFO holding fetched {pc, instr} entries; flush empties it in
// one cycle and wins over push/pop.
module fetch_queue #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  // A push into a full queue is legal only when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wptr] <= din;
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: issues sequential fetches, buffers returned words in
// a small queue and handles branch redirects including a stale in-flight ack.
import ProcessorStructs::*;

module instruction_fetch_unit #(
  parameter int unsigned     IBUS     = PKG_IBUS,
  parameter int unsigned     ABUS     = PKG_ABUS,
  parameter logic [ABUS-1:0] RESET_PC = '0,
  parameter int unsigned     DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [ABUS-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [IBUS-1:0] imem_rdata,
  input  logic            branch_taken,
  input  logic [ABUS-1:0] branch_target,
  input  logic            stall,
  output logic [IBUS-1:0] instruction,
  output logic [ABUS-1:0] pc_dir,
  output logic            valid
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  fetch_state_t           state, next_state;
  logic [ABUS-1:0]        pc, pc_next;
  logic                   push, pop, fills;
  logic [ABUS+IBUS-1:0]   q_din, q_dout;
  logic                   q_full, q_empty;
  logic [CW-1:0]          q_count;

  fetch_queue #(
    .DEPTH (DEPTH),
    .WIDTH (ABUS + IBUS)
  ) u_queue (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (branch_taken),
    .din   (q_din),
    .dout  (q_dout),
    .full  (q_full),
    .empty (q_empty),
    .count (q_count)
  );

  assign valid       = ~q_empty;
  assign pop         = valid & ~stall & ~branch_taken;
  assign q_din       = {pc, imem_rdata};
  assign imem_req    = rst & (state == FETCH) & ~q_full;
  assign imem_addr   = pc;
  assign instruction = q_empty ? IBUS'(NOP) : q_dout[IBUS-1:0];
  assign pc_dir      = q_empty ? pc : q_dout[ABUS+IBUS-1:IBUS];
  assign fills       = (q_count == CW'(DEPTH - 1)) & ~pop;

  always_comb begin
    next_state = state;
    pc_next    = pc;
    push       = 1'b0;
    unique case (state)
      FETCH: begin
        if (branch_taken) begin
          next_state = (imem_req && imem_ack) ? FETCH : DRAIN;
        end else if (imem_req && imem_ack) begin
          push    = 1'b1;
          pc_next = pc + ABUS'(4);
          if (fills) next_state = WAIT_SPACE;
        end
      end
      WAIT_SPACE: begin
        if (branch_taken || pop) next_state = FETCH;
      end
      DRAIN: begin
        // An ack coinciding with a second redirect still retires the stale request.
        if (imem_ack) next_state = FETCH;
      end
      default: next_state = FETCH;
    endcase
    if (branch_taken) pc_next = branch_target;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= FETCH;
      pc    <= RESET_PC;
    end else begin
      state <= next_state;
      pc    <= pc_next;
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: a per-cycle vector table plus
// reset-abandon and PC-wrap sequences.
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, imem_req, imem_ack, branch_taken, stall, valid;
  logic [31:0] imem_addr, imem_rdata, branch_target, instruction, pc_dir;

  logic        rst2, req2, ack2, valid2;
  logic [31:0] addr2, rdata2, instr2, pcdir2;
  logic        br2 = 1'b0;
  logic        stall2 = 1'b0;
  logic [31:0] tgt2 = '0;

  int checks = 0;
  int errors = 0;

  instruction_fetch_unit #(
    .IBUS(32), .ABUS(32), .RESET_PC(32'h0), .DEPTH(2)
  ) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .branch_taken(branch_taken),
    .branch_target(branch_target), .stall(stall), .instruction(instruction),
    .pc_dir(pc_dir), .valid(valid)
  );

  instruction_fetch_unit #(
    .IBUS(32), .ABUS(32), .RESET_PC(32'hFFFF_FFFC), .DEPTH(2)
  ) dut_wrap (
    .clk(clk), .rst(rst2), .imem_req(req2), .imem_addr(addr2),
    .imem_ack(ack2), .imem_rdata(rdata2), .branch_taken(br2),
    .branch_target(tgt2), .stall(stall2), .instruction(instr2),
    .pc_dir(pcdir2), .valid(valid2)
  );

  typedef struct {
    logic        br;
    logic [31:0] tgt;
    logic        stl;
    logic        ack;
    logic [31:0] rd;
    logic        req;
    logic [31:0] addr;
    logic        v;
    logic [31:0] pcd;
    logic [31:0] ins;
  } vec_t;

  vec_t vt [40];

  function automatic vec_t mk(input logic br, input logic [31:0] tgt, input logic stl,
                              input logic ack, input logic [31:0] rd, input logic req,
                              input logic [31:0] addr, input logic v,
                              input logic [31:0] pcd, input logic [31:0] ins);
    vec_t r;
    r.br = br; r.tgt = tgt; r.stl = stl; r.ack = ack; r.rd = rd;
    r.req = req; r.addr = addr; r.v = v; r.pcd = pcd; r.ins = ins;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic chk_main(input string nm, input logic req, input logic [31:0] addr,
                          input logic v, input logic [31:0] pcd, input logic [31:0] ins);
    chk({nm, "_req"},   {31'b0, imem_req}, {31'b0, req});
    chk({nm, "_addr"},  imem_addr, addr);
    chk({nm, "_valid"}, {31'b0, valid}, {31'b0, v});
    chk({nm, "_pcdir"}, pc_dir, pcd);
    chk({nm, "_instr"}, instruction, ins);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //            br tgt        st ack rdata         req addr        v pc_dir       instr
    vt[0]  = mk(0, 32'h0,     0, 1, 32'h10000000, 1, 32'h0,     0, 32'h0,     32'h0);
    vt[1]  = mk(0, 32'h0,     0, 1, 32'h10000004, 1, 32'h4,     1, 32'h0,     32'h10000000);
    vt[2]  = mk(0, 32'h0,     0, 1, 32'h10000008, 1, 32'h8,     1, 32'h4,     32'h10000004);
    vt[3]  = mk(0, 32'h0,     0, 0, 32'h0,        1, 32'hC,     1, 32'h8,     32'h10000008);
    vt[4]  = mk(0, 32'h0,     0, 0, 32'h0,        1, 32'hC,     0, 32'hC,     32'h0);
    vt[5]  = mk(0, 32'h0,     1, 1, 32'h1000000C, 1, 32'hC,     0, 32'hC,     32'h0);
    vt[6]  = mk(0, 32'h0,     1, 1, 32'h10000010, 1, 32'h10,    1, 32'hC,     32'h1000000C);
    vt[7]  = mk(0, 32'h0,     1, 1, 32'hDEADBEEF, 0, 32'h14,    1, 32'hC,     32'h1000000C);
    vt[8]  = mk(0, 32'h0,     1, 1, 32'hDEADBEEF, 0, 32'h14,    1, 32'hC,     32'h1000000C);
    vt[9]  = mk(0, 32'h0,     1, 1, 32'hDEADBEEF, 0, 32'h14,    1, 32'hC,     32'h1000000C);
    vt[10] = mk(0, 32'h0,     0, 0, 32'h0,        0, 32'h14,    1, 32'hC,     32'h1000000C);
    vt[11] = mk(0, 32'h0,     0, 0, 32'h0,        1, 32'h14,    1, 32'h10,    32'h10000010);
    vt[12] = mk(0, 32'h0,     0, 0, 32'h0,        1, 32'h14,    0, 32'h14,    32'h0);
    vt[13] = mk(0, 32'h0,     0, 0, 32'h0,        1, 32'h14,    0, 32'h14,    32'h0);
    vt[14] = mk(0, 32'h0,     0, 1, 32'h10000014, 1, 32'h14,    0, 32'h14,    32'h0);
    vt[15] = mk(0, 32'h0,     0, 0, 32'h0,        1, 32'h18,    1, 32'h14,    32'h10000014);
    vt[16] = mk(0, 32'h0,     0, 0, 32'h0,        1, 32'h18,    0, 32'h18,    32'h0);
    vt[17] = mk(0, 32'h0,     0, 1, 32'h10000018, 1, 32'h18,    0, 32'h18,    32'h0);
    vt[18] = mk(0, 32'h0,     0, 0, 32'h0,        1, 32'h1C,    1, 32'h18,    32'h10000018);
    vt[19] = mk(0, 32'h0,     1, 1, 32'h1000001C, 1, 32'h1C,    0, 32'h1C,    32'h0);
    vt[20] = mk(0, 32'h0,     1, 0, 32'h0,        1, 32'h20,    1, 32'h1C,    32'h1000001C);
    vt[21] = mk(1, 32'h100,   1, 0, 32'h0,        1, 32'h20,    1, 32'h1C,    32'h1000001C);
    vt[22] = mk(0, 32'h0,     0, 0, 32'h0,        0, 32'h100,   0, 32'h100,   32'h0);
    vt[23] = mk(0, 32'h0,     0, 1, 32'h0BADBAD0, 0, 32'h100,   0, 32'h100,   32'h0);
    vt[24] = mk(0, 32'h0,     0, 1, 32'h10000100, 1, 32'h100,   0, 32'h100,   32'h0);
    vt[25] = mk(0, 32'h0,     0, 0, 32'h0,        1, 32'h104,   1, 32'h100,   32'h10000100);
    vt[26] = mk(0, 32'h0,     0, 0, 32'h0,        1, 32'h104,   0, 32'h104,   32'h0);
    vt[27] = mk(1, 32'h200,   0, 1, 32'h0BADBAD1, 1, 32'h104,   0, 32'h104,   32'h0);
    vt[28] = mk(0, 32'h0,     0, 0, 32'h0,        1, 32'h200,   0, 32'h200,   32'h0);
    vt[29] = mk(0, 32'h0,     0, 1, 32'h10000200, 1, 32'h200,   0, 32'h200,   32'h0);
    vt[30] = mk(0, 32'h0,     0, 0, 32'h0,        1, 32'h204,   1, 32'h200,   32'h10000200);
    vt[31] = mk(1, 32'h300,   0, 0, 32'h0,        1, 32'h204,   0, 32'h204,   32'h0);
    vt[32] = mk(1, 32'h400,   0, 0, 32'h0,        0, 32'h300,   0, 32'h300,   32'h0);
    vt[33] = mk(0, 32'h0,     0, 1, 32'h0BADBAD2, 0, 32'h400,   0, 32'h400,   32'h0);
    vt[34] = mk(0, 32'h0,     0, 1, 32'h10000400, 1, 32'h400,   0, 32'h400,   32'h0);
    vt[35] = mk(0, 32'h0,     0, 0, 32'h0,        1, 32'h404,   1, 32'h400,   32'h10000400);
    vt[36] = mk(0, 32'h0,     1, 1, 32'h10000404, 1, 32'h404,   0, 32'h404,   32'h0);
    vt[37] = mk(0, 32'h0,     1, 1, 32'h10000408, 1, 32'h408,   1, 32'h404,   32'h10000404);
    vt[38] = mk(1, 32'h500,   1, 1, 32'h0BADBAD3, 0, 32'h40C,   1, 32'h404,   32'h10000404);
    vt[39] = mk(0, 32'h0,     0, 0, 32'h0,        1, 32'h500,   0, 32'h500,   32'h0);

    rst = 1'b0; imem_ack = 1'b0; imem_rdata = '0; branch_taken = 1'b0;
    branch_target = '0; stall = 1'b0;
    rst2 = 1'b0; ack2 = 1'b0; rdata2 = '0;

    repeat (2) @(negedge clk);
    #1;
    chk_main("reset", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);

    @(negedge clk);
    rst = 1'b1;
    #1;
    chk_main("release", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);

    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      branch_taken  = vt[i].br;
      branch_target = vt[i].tgt;
      stall         = vt[i].stl;
      imem_ack      = vt[i].ack;
      imem_rdata    = vt[i].rd;
      #1;
      chk_main($sformatf("row%0d", i), vt[i].req, vt[i].addr, vt[i].v, vt[i].pcd, vt[i].ins);
    end

    // Reset mid-request abandons the fetch at 0x500; an ack during reset is ignored.
    @(negedge clk);
    branch_taken = 1'b0; stall = 1'b0; imem_ack = 1'b0; imem_rdata = '0;
    rst = 1'b0;
    #1;
    chk_main("midrst", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    imem_ack = 1'b1; imem_rdata = 32'h0BADBAD4;
    #1;
    chk_main("midrst_ack", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    rst = 1'b1; imem_ack = 1'b0;
    #1;
    chk_main("rerel", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    imem_ack = 1'b1; imem_rdata = 32'h12345678;
    #1;
    chk_main("rerel_ack", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    imem_ack = 1'b0;
    #1;
    chk_main("rerel_out", 1'b1, 32'h4, 1'b1, 32'h0, 32'h12345678);

    // PC wrap from RESET_PC = 0xFFFFFFFC.
    chk("wrap_rst_addr", addr2, 32'hFFFF_FFFC);
    chk("wrap_rst_pcdir", pcdir2, 32'hFFFF_FFFC);
    chk("wrap_rst_req", {31'b0, req2}, 32'h0);
    @(negedge clk);
    rst2 = 1'b1; ack2 = 1'b1; rdata2 = 32'hCAFE0000;
    #1;
    chk("wrap_first_req", {31'b0, req2}, 32'h1);
    chk("wrap_first_addr", addr2, 32'hFFFF_FFFC);
    @(negedge clk);
    ack2 = 1'b0;
    #1;
    chk("wrap_next_addr", addr2, 32'h0);
    chk("wrap_valid", {31'b0, valid2}, 32'h1);
    chk("wrap_pcdir", pcdir2, 32'hFFFF_FFFC);
    chk("wrap_instr", instr2, 32'hCAFE0000);
    @(negedge clk);
    #1;
    chk("wrap_empty_pcdir", pcdir2, 32'h0);
    chk("wrap_empty_valid", {31'b0, valid2}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
